pipeline_hazard_controller: RTL and testbench
=============================================

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have ports: CLK  in  1  rising-edge clock; RESET_N  in  1  asynchronous active-low reset.
REQ-002 SHALL have ports: IF_ID_INSTR  in  32  instruction held in IF/ID (decode stage); ID_EX_MEMREAD  in  1  load in EX; ID_EX_RD  in  5  destination of instruction in EX.
REQ-003 SHALL have ports: BRANCH_TAKEN  in  1  EX redirect (branch taken/jump); DIV_DONE  in  1  divider result-valid pulse.
REQ-004 SHALL have ports: PC_WRITE  out  1  PC update enable; IF_ID_WRITE  out  1  IF/ID load enable; IF_ID_FLUSH  out  1  zero IF/ID; ID_EX_BUBBLE  out  1  insert NOP into ID/EX.
REQ-005 SHALL have ports: DIV_START  out  1  one-cycle divider launch; DIV_TIMEOUT  out  1  sticky error flag; STALL_COUNT  out  16  saturating stall-cycle counter; STATE  out  2  FSM state.
REQ-006 SHALL have parameter: DIV_TIMEOUT_CYC, default 40, maximum cycles waited for DIV_DONE.

Function
REQ-007 SHALL implement FSM states RUN=2'b00, LU_STALL=2'b01, DIV_BUSY=2'b10; 2'b11 SHALL be unreachable and SHALL return to RUN next cycle with outputs as RUN.
REQ-008 SHALL decode rs1=IF_ID_INSTR[19:15], rs2=[24:20], opcode=[6:0]; rs1 used unless opcode in {0110111, 0010111, 1101111}; rs2 used only for opcode in {0110011, 0100011, 1100011}.
REQ-009 SHALL define LU_HAZ = ID_EX_MEMREAD & (ID_EX_RD!=0) & ((rs1 used & rs1==ID_EX_RD) | (rs2 used & rs2==ID_EX_RD)).
REQ-010 SHALL define IS_DIV = opcode==0110011 & funct7==0000001 & funct3[2]==1 (DIV/DIVU/REM/REMU).
REQ-011 SHALL drive outputs combinationally from state and inputs; default (no event) PC_WRITE=1, IF_ID_WRITE=1, IF_ID_FLUSH=0, ID_EX_BUBBLE=0, DIV_START=0.
REQ-012 In RUN, priority SHALL be BRANCH_TAKEN > LU_HAZ > IS_DIV.
REQ-013 RUN & BRANCH_TAKEN: IF_ID_FLUSH=1, ID_EX_BUBBLE=1, PC_WRITE=1; stay RUN; no DIV_START, no stall count.
REQ-014 RUN & LU_HAZ (no branch): PC_WRITE=0, IF_ID_WRITE=0, ID_EX_BUBBLE=1; next state LU_STALL.
REQ-015 LU_STALL: default outputs (hazard resolved by forwarding), LU_HAZ ignored; next state RUN unconditionally; BRANCH_TAKEN here behaves as REQ-013 and next state RUN.
REQ-016 RUN & IS_DIV (no branch, no LU_HAZ): DIV_START=1 for exactly this cycle, PC_WRITE=0, IF_ID_WRITE=0, ID_EX_BUBBLE=1; timeout counter cleared; next state DIV_BUSY.
REQ-017 DIV_BUSY & !DIV_DONE: PC_WRITE=0, IF_ID_WRITE=0, ID_EX_BUBBLE=1, DIV_START=0; timeout counter increments; BRANCH_TAKEN ignored.
REQ-018 DIV_BUSY & DIV_DONE: default outputs (divide instruction advances to EX); next state RUN.
REQ-019 DIV_BUSY with timeout counter == DIV_TIMEOUT_CYC-1 and !DIV_DONE: DIV_TIMEOUT set to 1 (sticky until reset), default outputs that cycle, next state RUN.
REQ-020 DIV_DONE outside DIV_BUSY SHALL be ignored.
REQ-021 STALL_COUNT SHALL increment by 1 on every cycle where PC_WRITE=0, saturating at 16'hFFFF.

Reset
REQ-022 RESET_N low SHALL asynchronously force STATE=RUN, STALL_COUNT=0, DIV_TIMEOUT=0, timeout counter=0.
REQ-023 While RESET_N low, outputs SHALL be PC_WRITE=0, IF_ID_WRITE=0, IF_ID_FLUSH=1, ID_EX_BUBBLE=1, DIV_START=0.
REQ-024 Reset asserted in DIV_BUSY SHALL abandon the divide; no DIV_START after release until a new IS_DIV in RUN.

Verification
REQ-025 Load-use: ID_EX_MEMREAD=1, ID_EX_RD=5, IF_ID_INSTR=ADD x3,x5,x6 -> cycle 0 PC_WRITE=0, ID_EX_BUBBLE=1, STATE->01; cycle 1 defaults, STATE->00; STALL_COUNT=1.
REQ-026 x0 and unused-rs2 cases: ID_EX_RD=0 with rs1=0 -> no stall; ID_EX_RD=7 with ADDI x1,x2,imm where [24:20]=7 -> no stall.
REQ-027 Divide: DIVU in ID -> DIV_START pulse 1 cycle, STATE=10; DIV_DONE after 33 cycles -> release on DONE cycle, STALL_COUNT=33.
REQ-028 Priority: BRANCH_TAKEN=1 with LU_HAZ=1 and IS_DIV=1 -> IF_ID_FLUSH=1, ID_EX_BUBBLE=1, PC_WRITE=1, DIV_START=0, STATE stays 00.
REQ-029 Timeout: DIV issued, DIV_DONE never -> DIV_TIMEOUT=1 after 40 cycles in DIV_BUSY, STATE=00, flag holds until RESET_N low.
REQ-030 Reset mid-divide and saturation: RESET_N low in DIV_BUSY -> STATE=00, STALL_COUNT=0 immediately; preloaded 16'hFFFF count stays FFFF under further stalls.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: load-use interlock, branch flush and multi-cycle
// divide stall with timeout, plus a saturating stall-cycle counter.
module pipeline_hazard_controller #(
  parameter int DIV_TIMEOUT_CYC = 40
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] if_id_instr,
  input  logic        id_ex_memread,
  input  logic [4:0]  id_ex_rd,
  input  logic        branch_taken,
  input  logic        div_done,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        div_start,
  output logic        div_timeout,
  output logic [15:0] stall_count,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    DIV_BUSY = 2'b10,
    ILLEGAL  = 2'b11
  } state_t;

  localparam int TW = $clog2(DIV_TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(DIV_TIMEOUT_CYC - 1);

  state_t        state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          div_timeout_reg, div_timeout_next;
  logic [15:0]   stall_count_reg;

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       rs1_used;
  logic       rs2_used;
  logic       lu_haz;
  logic       is_div;
  logic       unused_bits;

  assign opcode   = if_id_instr[6:0];
  assign funct7   = if_id_instr[31:25];
  assign rs1      = if_id_instr[19:15];
  assign rs2      = if_id_instr[24:20];
  assign rs1_used = !((opcode == 7'b0110111) || (opcode == 7'b0010111) ||
                      (opcode == 7'b1101111));
  assign rs2_used = (opcode == 7'b0110011) || (opcode == 7'b0100011) ||
                    (opcode == 7'b1100011);
  assign lu_haz   = id_ex_memread && (id_ex_rd != 5'd0) &&
                    ((rs1_used && (rs1 == id_ex_rd)) || (rs2_used && (rs2 == id_ex_rd)));
  assign is_div   = (opcode == 7'b0110011) && (funct7 == 7'b0000001) && if_id_instr[14];
  assign unused_bits = ^if_id_instr[13:7];

  always_comb begin
    state_next       = RUN;
    timer_next       = timer_reg;
    div_timeout_next = div_timeout_reg;
    pc_write         = 1'b1;
    if_id_write      = 1'b1;
    if_id_flush      = 1'b0;
    id_ex_bubble     = 1'b0;
    div_start        = 1'b0;
    case (state_reg)
      RUN: begin
        if (branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (lu_haz) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          state_next   = LU_STALL;
        end else if (is_div) begin
          div_start    = 1'b1;
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          timer_next   = '0;
          state_next   = DIV_BUSY;
        end
      end
      LU_STALL: begin
        // The loaded value is forwardable now, so only a redirect matters here.
        if (branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end
      end
      DIV_BUSY: begin
        if (div_done) begin
          state_next = RUN;
        end else if (timer_reg == TIMER_LAST) begin
          div_timeout_next = 1'b1;
        end else begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          timer_next   = timer_reg + TW'(1);
          state_next   = DIV_BUSY;
        end
      end
      default: ;
    endcase
    // While held in reset the front end is frozen and EX is fed NOPs.
    if (!reset_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      div_start    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= RUN;
      timer_reg       <= '0;
      div_timeout_reg <= 1'b0;
      stall_count_reg <= 16'd0;
    end else begin
      state_reg       <= state_next;
      timer_reg       <= timer_next;
      div_timeout_reg <= div_timeout_next;
      if (!pc_write && (stall_count_reg != 16'hFFFF)) begin
        stall_count_reg <= stall_count_reg + 16'd1;
      end
    end
  end

  assign state       = state_reg;
  assign stall_count = stall_count_reg;
  assign div_timeout = div_timeout_reg;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed literal checks, then random
// stimulus compared every cycle against a cycle-indexed behavioural model.
module tb_pipeline_hazard_controller;

  localparam int TO = 40;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] ADD356  = {7'd0, 5'd6, 5'd5, 3'd0, 5'd3, 7'b0110011};
  localparam logic [31:0] ADDI_X0 = {12'd0, 5'd0, 3'd0, 5'd1, 7'b0010011};
  localparam logic [31:0] ADDI_I7 = {12'd7, 5'd2, 3'd0, 5'd1, 7'b0010011};
  localparam logic [31:0] DIVU123 = {7'b0000001, 5'd3, 5'd2, 3'b101, 5'd1, 7'b0110011};

  logic        clk;
  logic        reset_n;
  logic [31:0] if_id_instr;
  logic        id_ex_memread;
  logic [4:0]  id_ex_rd;
  logic        branch_taken;
  logic        div_done;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        div_start;
  logic        div_timeout;
  logic [15:0] stall_count;
  logic [1:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_hazard_controller #(.DIV_TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n), .if_id_instr(if_id_instr),
    .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
    .branch_taken(branch_taken), .div_done(div_done),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .div_start(div_start), .div_timeout(div_timeout),
    .stall_count(stall_count), .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0=run, 1=load-use shadow, 2=waiting on divider.
  int          m_mode  = 0;
  longint      cyc     = 0;
  longint      m_issue = 0;
  logic [15:0] m_cnt   = 16'd0;
  logic        m_to    = 1'b0;

  always @(negedge clk) begin
    logic [6:0] op;
    logic [4:0] r1, r2;
    logic u1, u2, haz, isdiv, set_to;
    logic e_pcw, e_ifw, e_fl, e_bub, e_ds;
    int n_mode;
    op    = if_id_instr[6:0];
    r1    = if_id_instr[19:15];
    r2    = if_id_instr[24:20];
    u1    = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
    u2    = op inside {7'b0110011, 7'b0100011, 7'b1100011};
    haz   = id_ex_memread && (id_ex_rd != 0) &&
            ((u1 && r1 == id_ex_rd) || (u2 && r2 == id_ex_rd));
    isdiv = (op == 7'b0110011) && (if_id_instr[31:25] == 7'b0000001) && if_id_instr[14];
    e_pcw = 1; e_ifw = 1; e_fl = 0; e_bub = 0; e_ds = 0; n_mode = 0; set_to = 0;
    if (!reset_n) begin
      m_mode = 0; m_cnt = 0; m_to = 0;
      e_pcw = 0; e_ifw = 0; e_fl = 1; e_bub = 1;
    end else if (m_mode == 0) begin
      if (branch_taken) begin
        e_fl = 1; e_bub = 1;
      end else if (haz) begin
        e_pcw = 0; e_ifw = 0; e_bub = 1; n_mode = 1;
      end else if (isdiv) begin
        e_ds = 1; e_pcw = 0; e_ifw = 0; e_bub = 1; n_mode = 2; m_issue = cyc;
      end
    end else if (m_mode == 1) begin
      if (branch_taken) begin
        e_fl = 1; e_bub = 1;
      end
    end else begin
      if (!div_done && (cyc - m_issue) < TO) begin
        e_pcw = 0; e_ifw = 0; e_bub = 1; n_mode = 2;
      end else if (!div_done) begin
        set_to = 1;
      end
    end
    check("pc_write", 32'(pc_write), 32'(e_pcw));
    check("if_id_write", 32'(if_id_write), 32'(e_ifw));
    check("if_id_flush", 32'(if_id_flush), 32'(e_fl));
    check("id_ex_bubble", 32'(id_ex_bubble), 32'(e_bub));
    check("div_start", 32'(div_start), 32'(e_ds));
    check("state", 32'(state), 32'(m_mode));
    check("stall_count", 32'(stall_count), 32'(m_cnt));
    check("div_timeout", 32'(div_timeout), 32'(m_to));
    if (reset_n) begin
      if (!e_pcw && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (set_to) m_to = 1;
      m_mode = n_mode;
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after a later rising edge.
  task automatic do_reset();
    reset_n = 0;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_count", 32'(stall_count), 32'd0);
    check("rst_timeout", 32'(div_timeout), 32'd0);
    @(negedge clk);
    check("rst_outs", {27'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble, div_start},
          32'b00110);
    step();
    reset_n = 1;
  endtask

  logic [6:0] op_tab [8] = '{7'b0110011, 7'b0010011, 7'b0100011, 7'b1100011,
                             7'b0110111, 7'b1101111, 7'b0000011, 7'b0010111};

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_rate;
    reset_n = 1; if_id_instr = NOP; id_ex_memread = 0; id_ex_rd = 0;
    branch_taken = 0; div_done = 0;
    #1;
    do_reset();

    // Load-use on rs1 of ADD x3,x5,x6
    id_ex_memread = 1; id_ex_rd = 5; if_id_instr = ADD356;
    @(negedge clk);
    check("lu_c0_pcw", 32'(pc_write), 32'd0);
    check("lu_c0_bubble", 32'(id_ex_bubble), 32'd1);
    step();
    check("lu_state01", 32'(state), 32'd1);
    @(negedge clk);
    check("lu_c1_pcw", 32'(pc_write), 32'd1);
    check("lu_c1_bubble", 32'(id_ex_bubble), 32'd0);
    check("lu_count", 32'(stall_count), 32'd1);
    step();
    check("lu_state00", 32'(state), 32'd0);

    // x0 destination and an I-type whose [24:20] is immediate
    id_ex_memread = 1; id_ex_rd = 0; if_id_instr = ADDI_X0;
    @(negedge clk);
    check("x0_nostall", 32'(pc_write), 32'd1);
    step();
    id_ex_rd = 7; if_id_instr = ADDI_I7;
    @(negedge clk);
    check("rs2unused_nostall", 32'(pc_write), 32'd1);
    step();
    id_ex_memread = 0; if_id_instr = NOP;

    // DIVU released by DIV_DONE 33 cycles after issue
    do_reset();
    if_id_instr = DIVU123;
    @(negedge clk);
    check("div_start_pulse", 32'(div_start), 32'd1);
    check("div_issue_pcw", 32'(pc_write), 32'd0);
    step();
    check("div_state10", 32'(state), 32'd2);
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (i == 1) check("div_start_once", 32'(div_start), 32'd0);
      step();
    end
    div_done = 1;
    @(negedge clk);
    check("div_release_pcw", 32'(pc_write), 32'd1);
    check("div_count33", 32'(stall_count), 32'd33);
    step();
    check("div_back_run", 32'(state), 32'd0);
    div_done = 0; if_id_instr = NOP;

    // Branch outranks load-use and divide
    branch_taken = 1; id_ex_memread = 1; id_ex_rd = 2; if_id_instr = DIVU123;
    @(negedge clk);
    check("prio_outs", {27'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble, div_start},
          32'b11110);
    step();
    check("prio_state", 32'(state), 32'd0);
    branch_taken = 0; id_ex_memread = 0; if_id_instr = NOP;

    // Divider never answers
    do_reset();
    if_id_instr = DIVU123;
    step();
    repeat (39) step();
    @(negedge clk);
    check("to_release_pcw", 32'(pc_write), 32'd1);
    check("to_not_yet", 32'(div_timeout), 32'd0);
    step();
    check("to_flag", 32'(div_timeout), 32'd1);
    check("to_state", 32'(state), 32'd0);
    check("to_count40", 32'(stall_count), 32'd40);
    if_id_instr = NOP;
    repeat (5) step();
    check("to_sticky", 32'(div_timeout), 32'd1);

    // Reset in the middle of a divide
    if_id_instr = DIVU123;
    step();
    check("mid_state10", 32'(state), 32'd2);
    step();
    reset_n = 0;
    #1;
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_count", 32'(stall_count), 32'd0);
    check("mid_rst_timeout", 32'(div_timeout), 32'd0);
    step();
    reset_n = 1; if_id_instr = NOP;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_no_start", 32'(div_start), 32'd0);
      step();
    end

    // Random phase
    done_rate = 4;
    for (int n = 0; n < 3000; n++) begin
      logic [6:0] op;
      if (n % 500 == 0) done_rate = ($urandom_range(0, 2) == 0) ? 60 : (($urandom_range(0, 1) == 0) ? 4 : 25);
      op = op_tab[$urandom_range(0, 7)];
      if_id_instr = {($urandom_range(0, 2) == 0) ? 7'b0000001 : 7'b0000000,
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), op};
      id_ex_memread = 1'($urandom_range(0, 1));
      id_ex_rd      = 5'($urandom_range(0, 7));
      branch_taken  = ($urandom_range(0, 7) == 0);
      div_done      = ($urandom_range(0, done_rate - 1) == 0);
      reset_n       = ($urandom_range(0, 299) != 0);
      step();
    end
    reset_n = 1;

    // Saturation: back-to-back timed-out divides until the counter pins
    branch_taken = 0; id_ex_memread = 0; div_done = 0; if_id_instr = NOP;
    step();
    do_reset();
    if_id_instr = DIVU123;
    for (int n = 0; n < 70000 && m_cnt != 16'hFFFF; n++) step();
    repeat (200) step();
    @(negedge clk);
    check("sat_hold", 32'(stall_count), 32'h0000FFFF);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
